// File: rtl/line_fill_server.sv
// line_fill_server: memory-side responder for cache line fills.
// Splits one line request into word reads on a narrow bus, packs the
// returned words (beat 0 in the MSBs) and signals completion with a
// single-cycle ready pulse.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a line request on strobe_i
// FILL  | issuing word reads, one outstanding at a time
// DONE  | line complete, ready_o pulses for this cycle only
// HOLD  | waiting for strobe_i low so its registered tail is not re-accepted
module line_fill_server #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  strobe_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  ready_o,
  output logic [LINE_SIZE-1:0]  data_o,
  output logic                  w_req_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  input  logic                  w_ack_i,
  input  logic [DATA_WIDTH-1:0] w_data_i
);

  localparam int WORDS  = LINE_SIZE / DATA_WIDTH;
  localparam int BEAT_W = $clog2(WORDS);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  // Line offset bits: beat index plus byte-in-word.
  localparam int OFFS_W = BEAT_W + BYTE_W;
  localparam int TAG_W  = ADDR_WIDTH - OFFS_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TAG_W-1:0]     base_q, base_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [LINE_SIZE-1:0] data_q, data_d;
  logic [BEAT_W-1:0]    beat_inc;
  logic                 last_beat;

  assign beat_inc  = beat_q + 1'b1;
  assign last_beat = (beat_q == BEAT_W'(WORDS - 1));

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      beat_q   <= '0;
      w_addr_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      w_addr_q <= w_addr_d;
      data_q   <= data_d;
    end
  end

  // Next-state, beat sequencing and line packing.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    beat_d   = beat_q;
    w_addr_d = w_addr_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (strobe_i) begin
          base_d   = addr_i[ADDR_WIDTH-1:OFFS_W];
          beat_d   = '0;
          w_addr_d = {addr_i[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (w_ack_i) begin
          for (int i = 0; i < WORDS; i++) begin
            if (beat_q == BEAT_W'(i)) begin
              data_d[LINE_SIZE-1-i*DATA_WIDTH -: DATA_WIDTH] = w_data_i;
            end
          end
          beat_d = beat_inc;
          // Tag bits come straight from base, so a beat never leaves the line.
          w_addr_d = {base_q, beat_inc, {BYTE_W{1'b0}}};
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!strobe_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state so reset removes them without a clock.
  assign ready_o  = (state_q == S_DONE);
  assign w_req_o  = (state_q == S_FILL);
  assign w_addr_o = w_addr_q;
  assign data_o   = data_q;

endmodule
